// File: rtl/io_tx_buffer_if.sv
// Bus bundle between the CPU memory-side I/O decode and the UART transmit path.
// The slave modport is the buffer itself; the master modport is the core/UART side.
interface io_tx_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  rdy_in;
  logic [31:0]           mem_a;
  logic [7:0]            mem_dout;
  logic                  mem_wr;
  logic                  io_buffer_full;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  program_stop;
  logic                  overflow;
  logic [DEPTH_LOG2:0]   fifo_count;

  modport slave (
    input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    output io_buffer_full, tx_data, tx_valid, program_stop, overflow, fifo_count
  );

  modport master (
    output rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    input  io_buffer_full, tx_data, tx_valid, program_stop, overflow, fifo_count
  );
endinterface

// File: rtl/io_tx_buffer.sv
// Byte FIFO between the CPU's memory-mapped UART/stop ports and the UART transmitter.
// Produces back-pressure to the core and a sticky program_stop once the stop byte drains.
module io_tx_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  io_tx_buffer_if.slave bus
);

  localparam int              DEPTH    = 1 << DEPTH_LOG2;
  localparam int              CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   MARGIN_C = CW'(FULL_MARGIN);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);

  function automatic logic f_near_full(input logic [CW-1:0] count);
    f_near_full = (DEPTH_C - count) <= MARGIN_C;
  endfunction

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_stop_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_stop_pending;
  logic                  r_stop_queued;
  logic                  r_stop_dropped;
  logic                  r_full;
  logic                  r_program_stop;
  logic                  r_overflow;

  logic                  w_io_wr;
  logic                  w_is_data;
  logic                  w_is_stop;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_tx_valid;
  logic [7:0]            w_push_data;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_stop_pending_nxt;
  logic                  w_stop_hit;
  logic                  w_last_drain;
  logic                  w_unused_addr;

  // Only the port-select and offset bits of the address take part in decoding.
  assign w_unused_addr = &{1'b0, bus.mem_a[31:18], bus.mem_a[15:3]};

  assign w_io_wr    = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:16] == 2'b11) && !r_stop_pending;
  assign w_is_data  = w_io_wr && (bus.mem_a[2:0] == 3'b000) && (bus.mem_dout != 8'h00);
  assign w_is_stop  = w_io_wr && (bus.mem_a[2:0] == 3'b100);
  assign w_push_req = w_is_data || w_is_stop;
  assign w_push_data = w_is_stop ? 8'h00 : bus.mem_dout;

  assign w_tx_valid = (r_count != '0);
  assign w_pop      = w_tx_valid && bus.tx_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push     = w_push_req && ((r_count != DEPTH_C) || w_pop);
  assign w_drop     = w_push_req && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + ONE_C;
      2'b01:   w_count_nxt = r_count - ONE_C;
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_stop_pending_nxt = r_stop_pending || w_is_stop;
  // Stop detection follows the marker position, never the byte value.
  assign w_stop_hit   = w_pop && r_stop_queued && (r_rd_ptr == r_stop_ptr);
  assign w_last_drain = w_pop && r_stop_dropped && (r_count == ONE_C);

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_stop_ptr     <= '0;
      r_count        <= '0;
      r_stop_pending <= 1'b0;
      r_stop_queued  <= 1'b0;
      r_stop_dropped <= 1'b0;
      r_full         <= 1'b0;
      r_program_stop <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count        <= w_count_nxt;
      r_stop_pending <= w_stop_pending_nxt;
      if (w_push && w_is_stop) begin
        r_stop_queued <= 1'b1;
        r_stop_ptr    <= r_wr_ptr;
      end
      if (w_drop && w_is_stop) begin
        r_stop_dropped <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_stop_hit || w_last_drain) begin
        r_program_stop <= 1'b1;
      end
      // Held high once stop is pending so the core stops issuing I/O writes.
      r_full <= f_near_full(w_count_nxt) || w_stop_pending_nxt;
    end
  end

  assign bus.tx_valid       = w_tx_valid;
  assign bus.tx_data        = w_tx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.io_buffer_full = r_full;
  assign bus.program_stop   = r_program_stop;
  assign bus.overflow       = r_overflow;
  assign bus.fifo_count     = r_count;

endmodule

// File: tb/tb_io_tx_buffer.sv
// Directed bench for io_tx_buffer with a byte scoreboard on the transmit side.
module tb_io_tx_buffer;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  io_tx_buffer_if #(.DEPTH_LOG2(4)) bus ();

  io_tx_buffer #(.DEPTH_LOG2(4), .FULL_MARGIN(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] sb [$];
  logic       pend = 1'b0;
  logic [7:0] pend_d = 8'h00;
  logic       stop_seen = 1'b0;
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a CPU write for the coming edge and record what the buffer should enqueue.
  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.rdy_in   = 1'b1;
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.mem_wr   = 1'b1;
    if (!stop_seen && a[17:16] == 2'b11) begin
      if (a[2:0] == 3'b000 && d != 8'h00) begin
        pend = 1'b1; pend_d = d;
      end else if (a[2:0] == 3'b100) begin
        pend = 1'b1; pend_d = 8'h00; stop_seen = 1'b1;
      end
    end
  endtask

  // Called at a falling edge: check the transmit side, update the scoreboard, advance one cycle.
  task automatic tick();
    int   pre_sz;
    logic pre_pop;
    #1;
    pre_sz  = sb.size();
    pre_pop = bus.tx_ready && (pre_sz != 0);
    chk("tx_valid", 32'(bus.tx_valid), 32'(pre_sz != 0));
    if (pre_pop) begin
      chk("tx_data", 32'(bus.tx_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (pend) begin
      if (pre_sz < 16 || pre_pop) sb.push_back(pend_d);
      else exp_ovf = 1'b1;
    end
    pend = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    bus.mem_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst_in       = 1'b1;
    bus.mem_wr   = 1'b0;
    bus.tx_ready = 1'b0;
    sb.delete();
    pend = 1'b0; stop_seen = 1'b0; exp_ovf = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_full"},  32'(bus.io_buffer_full), 32'd0);
    chk({tag, "_valid"}, 32'(bus.tx_valid),       32'd0);
    chk({tag, "_data"},  32'(bus.tx_data),        32'd0);
    chk({tag, "_stop"},  32'(bus.program_stop),   32'd0);
    chk({tag, "_ovf"},   32'(bus.overflow),       32'd0);
    chk({tag, "_count"}, 32'(bus.fifo_count),     32'd0);
  endtask

  initial begin
    bus.rdy_in = 1'b1; bus.mem_a = 32'h0; bus.mem_dout = 8'h0;
    bus.mem_wr = 1'b0; bus.tx_ready = 1'b0;

    // Reset state
    @(negedge clk_in);
    chk_idle_outputs("reset");
    do_reset();

    // "Hi" with the transmitter always ready
    bus.tx_ready = 1'b1;
    wr(32'h30000, 8'h48); tick();
    wr(32'h30000, 8'h69); tick();
    tick();
    tick();
    chk("hi_count", 32'(bus.fifo_count), 32'd0);

    // rdy_in low freezes capture
    bus.tx_ready = 1'b0;
    bus.rdy_in = 1'b0; bus.mem_a = 32'h30000; bus.mem_dout = 8'h55; bus.mem_wr = 1'b1;
    tick();
    chk("rdy_low_count", 32'(bus.fifo_count), 32'd0);

    // Fill to threshold, then one accepted and one dropped
    for (int i = 0; i < 15; i++) begin
      wr(32'h30000, 8'(8'h41 + i)); tick();
      chk("fill_full", 32'(bus.io_buffer_full), 32'(sb.size() >= 14));
    end
    chk("fill_count15", 32'(bus.fifo_count), 32'd15);
    wr(32'h30000, 8'h50); tick();
    chk("fill_ovf16", 32'(bus.overflow), 32'd0);
    wr(32'h30000, 8'h51); tick();
    chk("fill_ovf17", 32'(bus.overflow), 32'(exp_ovf));
    chk("fill_count16", 32'(bus.fifo_count), 32'd16);

    // Push and pop at full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr(32'h30000, 8'(8'h61 + i)); tick();
    end
    bus.tx_ready = 1'b1;
    wr(32'h30000, 8'h5A); tick();
    chk("fullpp_count", 32'(bus.fifo_count), 32'd16);
    chk("fullpp_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 17; i++) tick();
    chk("fullpp_drained", 32'(bus.fifo_count), 32'd0);
    chk("fullpp_sb", 32'(sb.size()), 32'd0);

    // Zero byte to the UART port is ignored
    wr(32'h30000, 8'h00); tick();
    chk("zero_count", 32'(bus.fifo_count), 32'd0);
    chk("zero_ovf", 32'(bus.overflow), 32'd0);
    chk("zero_valid", 32'(bus.tx_valid), 32'd0);

    // Stop write queued behind a user byte
    bus.tx_ready = 1'b0;
    wr(32'h30000, 8'h41); tick();
    chk("stop_full_pre", 32'(bus.io_buffer_full), 32'd0);
    wr(32'h30004, 8'h99); tick();
    chk("stop_full", 32'(bus.io_buffer_full), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("stop_count", 32'(bus.fifo_count), 32'd2);
    chk("stop_pstop_hold", 32'(bus.program_stop), 32'd0);
    bus.tx_ready = 1'b1;
    tick();
    chk("stop_pstop_after_A", 32'(bus.program_stop), 32'd0);
    tick();
    chk("stop_pstop", 32'(bus.program_stop), 32'd1);
    wr(32'h30000, 8'h42); tick();
    chk("stop_ignored_count", 32'(bus.fifo_count), 32'd0);
    chk("stop_sticky", 32'(bus.program_stop), 32'd1);
    chk("stop_full_sticky", 32'(bus.io_buffer_full), 32'd1);

    // Stop write dropped on a full FIFO
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr(32'h30000, 8'(8'h30 + i)); tick();
    end
    wr(32'h30004, 8'h00); tick();
    chk("dstop_ovf", 32'(bus.overflow), 32'd1);
    chk("dstop_count", 32'(bus.fifo_count), 32'd16);
    chk("dstop_full", 32'(bus.io_buffer_full), 32'd1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("dstop_pstop_early", 32'(bus.program_stop), 32'd0);
    tick();
    chk("dstop_pstop", 32'(bus.program_stop), 32'd1);
    chk("dstop_empty", 32'(bus.fifo_count), 32'd0);

    // Asynchronous reset in the middle of a cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr(32'h30000, 8'(8'h70 + i)); tick();
    end
    chk("ares_count4", 32'(bus.fifo_count), 32'd4);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk_idle_outputs("ares");
    sb.delete(); exp_ovf = 1'b0; stop_seen = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    wr(32'h30000, 8'h5A); tick();
    chk("ares_after_count", 32'(bus.fifo_count), 32'd1);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    chk("ares_drained", 32'(bus.fifo_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
